// File: rtl/exc_ctrl_if.sv
// rtl/exc_ctrl_if.sv - pipeline/CP0 side bus of the exception sequencer
//
// Purpose : bundles the commit-boundary request inputs, the CP0 status
//           inputs and the sequencer outputs into one interface.
// Modports: slave  - exc_ctrl side (requests in, control out)
//           master - pipeline/CP0 side (requests out, control in)
// Signals : hw_irq[4:0], inst_valid, inst_pc[31:0], exc_sys, exc_bp,
//           exc_ri, exc_ov, eret, SR_IM[7:0], SR_IE, EPC[31:0]  (to sequencer)
//           ExcEnter, ExcCode[4:0], HWInt[4:0], epc_out[31:0], stall,
//           flush, pc_load, pc_target[31:0]                     (from sequencer)

interface exc_ctrl_if;
    logic [4:0]  hw_irq;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic        exc_sys;
    logic        exc_bp;
    logic        exc_ri;
    logic        exc_ov;
    logic        eret;
    logic [7:0]  SR_IM;
    logic        SR_IE;
    logic [31:0] EPC;

    logic        ExcEnter;
    logic [4:0]  ExcCode;
    logic [4:0]  HWInt;
    logic [31:0] epc_out;
    logic        stall;
    logic        flush;
    logic        pc_load;
    logic [31:0] pc_target;

    modport slave (
        input  hw_irq, inst_valid, inst_pc, exc_sys, exc_bp, exc_ri, exc_ov,
               eret, SR_IM, SR_IE, EPC,
        output ExcEnter, ExcCode, HWInt, epc_out, stall, flush, pc_load,
               pc_target
    );

    modport master (
        output hw_irq, inst_valid, inst_pc, exc_sys, exc_bp, exc_ri, exc_ov,
               eret, SR_IM, SR_IE, EPC,
        input  ExcEnter, ExcCode, HWInt, epc_out, stall, flush, pc_load,
               pc_target
    );
endinterface

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception/interrupt entry and ERET sequencer for CP0
//
// Purpose : picks one exception/interrupt/ERET per IDLE cycle by fixed
//           priority and drives the CP0 save strobe, pipeline stall/flush
//           and PC redirect as a fixed four-state sequence.
// Ports   : clk   - system clock
//           reset - synchronous active-low reset
//           bus   - exc_ctrl_if.slave (requests, CP0 status, control outputs)
// Config  : EXC_IRQ_SYNC_EN - when defined, hw_irq passes a 2-flop
//           synchronizer before masking; otherwise it is used directly.

module exc_ctrl (
    input  logic       clk,
    input  logic       reset,
    exc_ctrl_if.slave  bus
);

    localparam logic [31:0] VECTOR = 32'h0000_4180;

    localparam logic [4:0] CODE_INT = 5'd0;
    localparam logic [4:0] CODE_SYS = 5'd8;
    localparam logic [4:0] CODE_BP  = 5'd9;
    localparam logic [4:0] CODE_RI  = 5'd10;
    localparam logic [4:0] CODE_OV  = 5'd12;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ENTER    = 2'd1,
        REDIRECT = 2'd2,
        RETURN   = 2'd3
    } state_t;

    state_t      state;
    logic [4:0]  irq_in;
    logic [4:0]  pend;
    logic        irq_take;
    logic        win_exc;
    logic [4:0]  win_code;

    logic        exc_enter_q;
    logic [4:0]  exc_code_q;
    logic [4:0]  hw_int_q;
    logic [31:0] epc_out_q;
    logic        stall_q;
    logic        flush_q;
    logic        pc_load_q;
    logic [31:0] pc_target_q;

    // Only SR_IM[6:2] gate hardware lines; the two software bits and IM7 are
    // handled elsewhere in CP0.
    wire unused_im = &{1'b0, bus.SR_IM[7], bus.SR_IM[1:0]};

`ifdef EXC_IRQ_SYNC_EN
    logic [4:0] sync1;
    logic [4:0] sync2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.hw_irq;
            sync2 <= sync1;
        end
    end

    assign irq_in = sync2;
`else
    assign irq_in = bus.hw_irq;
`endif

    assign pend     = irq_in & bus.SR_IM[6:2];
    assign irq_take = bus.SR_IE & (|pend) & bus.inst_valid;

    // Fixed priority among synchronous exceptions, then interrupts. Exception
    // requests only mean something while an instruction is at commit.
    always_comb begin
        win_exc  = 1'b1;
        win_code = CODE_INT;
        if (bus.inst_valid && bus.exc_ri) begin
            win_code = CODE_RI;
        end else if (bus.inst_valid && bus.exc_ov) begin
            win_code = CODE_OV;
        end else if (bus.inst_valid && bus.exc_sys) begin
            win_code = CODE_SYS;
        end else if (bus.inst_valid && bus.exc_bp) begin
            win_code = CODE_BP;
        end else if (irq_take) begin
            win_code = CODE_INT;
        end else begin
            win_exc = 1'b0;
        end
    end

    // Outputs are registered against the state being entered, so each one is
    // a pure function of the current state (plus the held latches).
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            exc_enter_q <= 1'b0;
            exc_code_q  <= '0;
            hw_int_q    <= '0;
            epc_out_q   <= '0;
            stall_q     <= 1'b0;
            flush_q     <= 1'b0;
            pc_load_q   <= 1'b0;
            pc_target_q <= '0;
        end else begin
            exc_enter_q <= 1'b0;
            stall_q     <= 1'b0;
            flush_q     <= 1'b0;
            pc_load_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_exc) begin
                        state       <= ENTER;
                        exc_enter_q <= 1'b1;
                        stall_q     <= 1'b1;
                        exc_code_q  <= win_code;
                        hw_int_q    <= pend;
                        epc_out_q   <= bus.inst_pc;
                    end else if (bus.eret) begin
                        // EPC is captured on the edge into RETURN so that
                        // pc_target is already stable during that cycle.
                        state       <= RETURN;
                        flush_q     <= 1'b1;
                        pc_load_q   <= 1'b1;
                        pc_target_q <= bus.EPC;
                    end
                end
                ENTER: begin
                    state       <= REDIRECT;
                    stall_q     <= 1'b1;
                    flush_q     <= 1'b1;
                    pc_load_q   <= 1'b1;
                    pc_target_q <= VECTOR;
                end
                REDIRECT: state <= IDLE;
                RETURN:   state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    assign bus.ExcEnter  = exc_enter_q;
    assign bus.ExcCode   = exc_code_q;
    assign bus.HWInt     = hw_int_q;
    assign bus.epc_out   = epc_out_q;
    assign bus.stall     = stall_q;
    assign bus.flush     = flush_q;
    assign bus.pc_load   = pc_load_q;
    assign bus.pc_target = pc_target_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - scoreboard bench for exc_ctrl

module tb_exc_ctrl;

    logic clk;
    logic reset;

    exc_ctrl_if bus ();

    exc_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    logic [77:0] exp_q[$];
    string       tag_q[$];

    // Reference view of the held CP0-facing values.
    logic [4:0]  m_code;
    logic [4:0]  m_hw;
    logic [31:0] m_epc;
    logic [31:0] m_tgt;

    task automatic check_eq(input string tag, input logic [77:0] obs,
                            input logic [77:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [77:0] pack(input logic ee, input logic [4:0] code,
                                         input logic [4:0] hw, input logic [31:0] epc,
                                         input logic st, input logic fl,
                                         input logic pl, input logic [31:0] tgt);
        return {ee, code, hw, epc, st, fl, pl, tgt};
    endfunction

    // Push the expected post-edge outputs, advance one clock, then compare.
    task automatic cyc(input string tag, input logic ee, input logic st,
                       input logic fl, input logic pl);
        logic [77:0] e;
        string       t;
        exp_q.push_back(pack(ee, m_code, m_hw, m_epc, st, fl, pl, m_tgt));
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_eq(t, pack(bus.ExcEnter, bus.ExcCode, bus.HWInt, bus.epc_out,
                         bus.stall, bus.flush, bus.pc_load, bus.pc_target), e);
    endtask

    task automatic clear_req();
        bus.exc_sys    = 1'b0;
        bus.exc_bp     = 1'b0;
        bus.exc_ri     = 1'b0;
        bus.exc_ov     = 1'b0;
        bus.eret       = 1'b0;
        bus.inst_valid = 1'b0;
        bus.hw_irq     = 5'h00;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_code = '0; m_hw = '0; m_epc = '0; m_tgt = '0;

        clear_req();
        bus.inst_pc = 32'h0;
        bus.SR_IM   = 8'hFF;
        bus.SR_IE   = 1'b1;
        bus.EPC     = 32'h0;

        // Reset held with live requests.
        reset          = 1'b0;
        bus.hw_irq     = 5'h1F;
        bus.exc_ri     = 1'b1;
        bus.inst_valid = 1'b1;
        for (int i = 0; i < 3; i++) cyc("reset_hold", 0, 0, 0, 0);
        clear_req();
        reset = 1'b1;
        cyc("reset_release", 0, 0, 0, 0);

        // Syscall entry.
        bus.inst_valid = 1'b1;
        bus.inst_pc    = 32'h0000_3010;
        bus.exc_sys    = 1'b1;
        m_code = 5'd8; m_hw = 5'h00; m_epc = 32'h0000_3010;
        cyc("sys_enter", 1, 1, 0, 0);
        clear_req();
        m_tgt = 32'h0000_4180;
        cyc("sys_redirect", 0, 1, 1, 1);
        cyc("sys_idle", 0, 0, 0, 0);

        // Priority: overflow beats syscall and the pending interrupt.
        bus.hw_irq = 5'h01;
        cyc("pri_wait0", 0, 0, 0, 0);
        cyc("pri_wait1", 0, 0, 0, 0);
        bus.inst_valid = 1'b1;
        bus.exc_ov     = 1'b1;
        bus.exc_sys    = 1'b1;
        bus.inst_pc    = 32'h0000_3020;
        m_code = 5'd12; m_hw = 5'h01; m_epc = 32'h0000_3020;
        cyc("pri_ov_enter", 1, 1, 0, 0);
        bus.exc_ov  = 1'b0;
        bus.exc_sys = 1'b0;
        cyc("pri_ov_redirect", 0, 1, 1, 1);
        bus.inst_pc = 32'h0000_3030;
        cyc("pri_ov_idle", 0, 0, 0, 0);
        m_code = 5'd0; m_hw = 5'h01; m_epc = 32'h0000_3030;
        cyc("pri_irq_enter", 1, 1, 0, 0);
        // Dropping SR_IE mid-sequence must not disturb it.
        bus.SR_IE  = 1'b0;
        bus.hw_irq = 5'h00;
        cyc("pri_irq_redirect", 0, 1, 1, 1);
        cyc("pri_irq_idle", 0, 0, 0, 0);
        cyc("pri_irq_idle2", 0, 0, 0, 0);
        bus.SR_IE = 1'b1;

        // Masking via SR_IM[4].
        bus.hw_irq     = 5'b00100;
        bus.SR_IM      = 8'hEF;
        bus.inst_valid = 1'b1;
        for (int i = 0; i < 3; i++) cyc("mask_im_off", 0, 0, 0, 0);
        bus.SR_IM   = 8'hFF;
        bus.inst_pc = 32'h0000_3040;
        m_code = 5'd0; m_hw = 5'b00100; m_epc = 32'h0000_3040;
        cyc("mask_im_enter", 1, 1, 0, 0);
        clear_req();
        cyc("mask_im_redirect", 0, 1, 1, 1);
        cyc("mask_im_idle", 0, 0, 0, 0);
        bus.SR_IE      = 1'b0;
        bus.hw_irq     = 5'b00100;
        bus.inst_valid = 1'b1;
        for (int i = 0; i < 3; i++) cyc("mask_ie_off", 0, 0, 0, 0);
        clear_req();
        bus.SR_IE = 1'b1;
        cyc("mask_settle0", 0, 0, 0, 0);
        cyc("mask_settle1", 0, 0, 0, 0);

        // ERET.
        bus.EPC        = 32'h0000_3014;
        bus.eret       = 1'b1;
        bus.inst_valid = 1'b1;
        m_tgt = 32'h0000_3014;
        cyc("eret_return", 0, 0, 1, 1);
        clear_req();
        cyc("eret_idle", 0, 0, 0, 0);

        // Break together with ERET: the exception wins.
        bus.inst_valid = 1'b1;
        bus.exc_bp     = 1'b1;
        bus.eret       = 1'b1;
        bus.inst_pc    = 32'h0000_3050;
        m_code = 5'd9; m_hw = 5'h00; m_epc = 32'h0000_3050;
        cyc("bp_eret_enter", 1, 1, 0, 0);
        clear_req();
        m_tgt = 32'h0000_4180;
        cyc("bp_eret_redirect", 0, 1, 1, 1);
        cyc("bp_eret_idle", 0, 0, 0, 0);

        // Reset during ENTER.
        bus.inst_valid = 1'b1;
        bus.exc_ri     = 1'b1;
        bus.inst_pc    = 32'h0000_3060;
        m_code = 5'd10; m_epc = 32'h0000_3060;
        cyc("ri_enter", 1, 1, 0, 0);
        clear_req();
        reset = 1'b0;
        m_code = '0; m_hw = '0; m_epc = '0; m_tgt = '0;
        cyc("rst_mid", 0, 0, 0, 0);
        reset = 1'b1;
        cyc("rst_mid_idle", 0, 0, 0, 0);

        // Fresh entry right after the aborted one.
        bus.inst_valid = 1'b1;
        bus.exc_sys    = 1'b1;
        bus.inst_pc    = 32'h0000_3070;
        m_code = 5'd8; m_epc = 32'h0000_3070;
        cyc("post_rst_enter", 1, 1, 0, 0);
        clear_req();
        m_tgt = 32'h0000_4180;
        cyc("post_rst_redirect", 0, 1, 1, 1);
        cyc("post_rst_idle", 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception/interrupt sequencer in front of the CP0 register block. Samples hardware interrupt lines and synchronous exception requests from the pipeline, picks one by fixed priority, and drives a cycle-exact entry sequence: CP0 save pulse, pipeline stall/flush, PC redirect to the handler vector. Also sequences ERET, redirecting the PC to EPC. Sits between the pipeline control unit, the PC register and CP0.

## Interface
- VECTOR, 32'h0000_4180, handler entry address loaded into PC on exception/interrupt entry
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- hw_irq  in  5  level-sensitive hardware interrupt requests
- inst_valid  in  1  an instruction is at the commit boundary this cycle; interrupts are accepted only when high
- inst_pc  in  32  PC of the instruction at the commit boundary
- exc_sys, exc_bp, exc_ri, exc_ov  in  1 each  syscall, break, reserved instruction, overflow; valid only with inst_valid
- eret  in  1  ERET at the commit boundary
- SR_IM  in  8  CP0 mask bits; SR_IM[6:2] mask hw_irq[4:0]
- SR_IE  in  1  CP0 global interrupt enable
- EPC  in  32  current CP0 EPC
- ExcEnter  out  1  one-cycle CP0 save strobe
- ExcCode  out  5  cause code for CP0
- HWInt  out  5  pending-interrupt snapshot for CP0 cause[14:10]
- epc_out  out  32  PC to save; muxed onto CP0 Din while ExcEnter=1
- stall  out  1  freeze pipeline
- flush  out  1  kill all in-flight instructions
- pc_load  out  1  load PC from pc_target
- pc_target  out  32  redirect address

## Operation
- States: IDLE, ENTER, REDIRECT, RETURN.
- pend[4:0] = hw_irq (after optional synchronizer) & SR_IM[6:2]; irq_take = SR_IE & |pend & inst_valid.
- IDLE priority, highest first: exc_ri (code 10), exc_ov (12), exc_sys (8), exc_bp (9), irq_take (0), eret. Only the winner acts; losing interrupts stay pending (level) and are re-evaluated in IDLE.
- Exception/interrupt win: latch code, latch epc_out = inst_pc, latch HWInt = pend; go ENTER.
- ENTER: ExcEnter=1, stall=1, ExcCode/HWInt/epc_out held from latch; go REDIRECT.
- REDIRECT: flush=1, stall=1, pc_load=1, pc_target=VECTOR; go IDLE.
- eret win (no exception): go RETURN. RETURN: flush=1, pc_load=1, pc_target=EPC sampled in RETURN; go IDLE.
- Exception inputs are ignored outside IDLE; the pipeline is stalled then and does not present new instructions.
- ExcCode, HWInt and epc_out retain their last latched value outside ENTER; only ExcEnter qualifies them.

## Timing
- Reset (reset=0 at posedge): state=IDLE; ExcEnter, stall, flush, pc_load = 0; ExcCode=0, HWInt=0, epc_out=0, pc_target=0; synchronizer flops cleared.
- Reset asserted in any state aborts the sequence at the next edge; no partial ExcEnter or pc_load after reset.
- Synchronous exception: request in cycle N (IDLE) -> ExcEnter in N+1 -> pc_load/flush in N+2 -> IDLE in N+3, earliest re-entry N+3.
- Interrupt: hw_irq rise in cycle N -> pend visible N+2 with synchronizer (N without) -> entry as above once inst_valid=1.
- ERET: eret in N -> pc_load with pc_target=EPC in N+1 -> IDLE in N+2.
- All outputs registered, state-decoded; no combinational path from inputs to outputs.
- Same cycle exception + eret: exception wins, eret dropped (pipeline re-issues it after handler return).
- SR_IE dropping while in ENTER/REDIRECT has no effect on the sequence in progress.

## Configuration
- EXC_IRQ_SYNC_EN defined: hw_irq passes through a 2-flop synchronizer before masking; interrupt latency +2 cycles.
- Undefined: hw_irq is used directly (sources must be synchronous to clk); no synchronizer flops.

## Test plan
- Reset: hold reset=0 3 cycles with hw_irq=5'h1F, exc_ri=1 -> all outputs 0, state IDLE, no ExcEnter for 1 cycle after release with inputs cleared.
- Syscall: inst_pc=32'h0000_3010, exc_sys=1 -> ExcEnter next cycle with ExcCode=8, epc_out=32'h0000_3010; following cycle pc_load=1, pc_target=32'h0000_4180, flush=1.
- Priority: exc_ov=1, exc_sys=1, hw_irq[0]=1 same cycle, SR_IE=1, SR_IM=8'hFF -> ExcCode=12; after return to IDLE, pending irq taken with ExcCode=0, HWInt=5'h01.
- Masking: hw_irq=5'b00100, SR_IM[4]=0 -> no entry; set SR_IM[4]=1 -> entry with HWInt=5'b00100; SR_IE=0 -> no entry.
- ERET: EPC=32'h0000_3014, eret=1 -> next cycle pc_load=1, pc_target=32'h0000_3014, flush=1, no ExcEnter.
- Reset mid-sequence: reset=0 during ENTER -> next cycle ExcEnter=0, pc_load=0, state IDLE.
